// File: rtl/multdiv_unit_pkg.sv
// multdiv_unit_pkg: shared constants and state type for the multiply/divide unit
package multdiv_unit_pkg;
   localparam int WIDTH = 32;
   localparam int ITERS = 32;
   localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/multdiv_unit_cla32.sv
// multdiv_unit_cla32: 32-bit adder, 4-bit lookahead groups with group carries
// computed from group generate/propagate
module multdiv_unit_cla32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] sum_o,
   output logic        cout_o
);
   logic [31:0] g, p;
   logic [32:0] c;
   logic gg, pp;
   assign g = a_i & b_i;
   assign p = a_i ^ b_i;
   always_comb begin
      c = '0;
      gg = 1'b0;
      pp = 1'b1;
      c[0] = cin_i;
      for (int k = 0; k < 8; k++) begin
         gg = 1'b0;
         pp = 1'b1;
         for (int j = 0; j < 4; j++) begin
            gg = g[4*k+j] | (p[4*k+j] & gg);
            pp = pp & p[4*k+j];
            if (j < 3) c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
         end
         c[4*k+4] = gg | (pp & c[4*k]);
      end
   end
   assign sum_o  = p ^ c[31:0];
   assign cout_o = c[32];
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (radix-2 Booth) / divide (non-restoring)
// sharing one 33-bit add/subtract path; 32 iterations then a one-cycle ready strobe
module multdiv_unit
   import multdiv_unit_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);
   state_e state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic [WIDTH:0] acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d, a_q, a_d, b_q, b_d, res_q, res_d;
   logic qm1_q, qm1_d, exc_q, exc_d;
   logic [WIDTH:0] x, y, ys, sum, t;
   logic [WIDTH-1:0] sum_lo, b_abs, a_abs, quo, res_div;
   logic is_mul, is_div, sub, cout, last, exc_div;
   assign is_mul = state_q == MUL;
   assign is_div = state_q == DIV;
   assign a_abs  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign b_abs  = b_q[WIDTH-1] ? -b_q : b_q;
   // Multiply accumulates into hi; divide shifts the next dividend bit into the remainder
   assign x   = is_mul ? acc_q : {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
   assign y   = is_mul ? {b_q[WIDTH-1], b_q} : {1'b0, b_abs};
   assign sub = is_mul ? lo_q[0] & ~qm1_q : ~acc_q[WIDTH];
   assign ys  = sub ? ~y : y;
   multdiv_unit_cla32 u_add (
      .a_i   (x[WIDTH-1:0]),
      .b_i   (ys[WIDTH-1:0]),
      .cin_i (sub),
      .sum_o (sum_lo),
      .cout_o(cout)
   );
   assign sum     = {x[WIDTH] ^ ys[WIDTH] ^ cout, sum_lo};
   assign t       = (lo_q[0] == qm1_q) ? acc_q : sum;
   assign last    = cnt_q == 6'(ITERS - 1);
   assign quo     = {lo_q[WIDTH-2:0], ~sum[WIDTH]};
   assign res_div = (b_q == '0) ? '0 : (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo : quo;
   assign exc_div = (b_q == '0) | ((a_q == INT_MIN) & (b_q == '1));
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      qm1_d   = qm1_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      exc_d   = exc_q;
      if (is_mul) begin
         acc_d = {t[WIDTH], t[WIDTH:1]};
         lo_d  = {t[0], lo_q[WIDTH-1:1]};
         qm1_d = lo_q[0];
      end else if (is_div) begin
         acc_d = sum;
         lo_d  = quo;
      end
      if (is_mul || is_div) begin
         cnt_d = cnt_q + 6'd1;
         if (last) begin
            state_d = DONE;
            // t is product[63:31]; it must be all-equal for the product to fit
            res_d   = is_mul ? lo_d : res_div;
            exc_d   = is_mul ? ~(&t | ~|t) : exc_div;
         end
      end
      if (state_q == DONE) state_d = IDLE;
      if (ctrl_MULT || ctrl_DIV) begin
         state_d = ctrl_MULT ? MUL : DIV;
         cnt_d   = '0;
         acc_d   = '0;
         lo_d    = ctrl_MULT ? data_operandA : a_abs;
         qm1_d   = 1'b0;
         a_d     = data_operandA;
         b_d     = data_operandB;
         res_d   = res_q;
         exc_d   = exc_q;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         qm1_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         qm1_q   <= qm1_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
      end
   end
   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = state_q == DONE;
   assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: scoreboard bench; driver queues expected results from an
// arithmetic model, a negedge monitor checks ready strobes, latency and busy
module tb_multdiv_unit;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [31:0] opa = '0, opb = '0;
   logic cm = 1'b0, cd = 1'b0;
   logic [31:0] data_result;
   logic data_exception, data_resultRDY, busy;
   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          cyc;
      string       name;
   } exp_t;
   exp_t sb[$];
   int cyc = 0;
   int checks = 0;
   int passed = 0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   multdiv_unit dut (
      .clock         (clock),
      .reset         (reset),
      .data_operandA (opa),
      .data_operandB (opb),
      .ctrl_MULT     (cm),
      .ctrl_DIV      (cd),
      .data_result   (data_result),
      .data_exception(data_exception),
      .data_resultRDY(data_resultRDY),
      .busy          (busy)
   );
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, req);
   endtask
   function automatic exp_t model(input bit is_div, input logic [31:0] x, input logic [31:0] y, input string nm);
      exp_t e;
      longint p;
      e.name = nm;
      e.cyc  = 0;
      if (!is_div) begin
         p     = longint'($signed(x)) * longint'($signed(y));
         e.res = p[31:0];
         e.exc = p != longint'($signed(p[31:0]));
      end else if (y == 32'd0) begin
         e.res = 32'd0;
         e.exc = 1'b1;
      end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         e.res = 32'h8000_0000;
         e.exc = 1'b1;
      end else begin
         e.res = 32'($signed(x) / $signed(y));
         e.exc = 1'b0;
      end
      return e;
   endfunction
   always @(negedge clock) begin : monitor
      exp_t e;
      check("busy", 32'(busy), 32'(sb.size() != 0));
      if (data_resultRDY) begin
         if (sb.size() == 0) check("unexpected_rdy", 32'(data_resultRDY), 32'd0);
         else begin
            e = sb.pop_front();
            check({e.name, "_result"}, data_result, e.res);
            check({e.name, "_exception"}, 32'(data_exception), 32'(e.exc));
            check({e.name, "_rdy_cycle"}, 32'(cyc), 32'(e.cyc));
         end
      end
   end
   // op bit0 = ctrl_MULT, bit1 = ctrl_DIV; a new start replaces any pending expectation
   task automatic start(input int op, input logic [31:0] x, input logic [31:0] y, input string nm);
      exp_t e;
      @(negedge clock);
      opa = x;
      opb = y;
      cm  = op[0];
      cd  = op[1];
      @(posedge clock);
      #1;
      cm = 1'b0;
      cd = 1'b0;
      e = model(!op[0], x, y, nm);
      e.cyc = cyc + 32;
      sb.delete();
      sb.push_back(e);
   endtask
   task automatic wait_done();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL timeout: %s still pending, no ready strobe", sb[0].name);
         sb.delete();
      end
   endtask
   task automatic run(input int op, input logic [31:0] x, input logic [31:0] y, input string nm);
      start(op, x, y, nm);
      wait_done();
   endtask
   initial begin
      logic [31:0] x, y;
      int op;
      #1;
      check("reset_result", data_result, 32'd0);
      check("reset_exception", 32'(data_exception), 32'd0);
      check("reset_rdy", 32'(data_resultRDY), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      run(1, 32'd7, -32'sd3, "mul_7x-3");
      run(1, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
      run(1, 32'h8000_0000, 32'd1, "mul_intmin");
      run(2, -32'sd7, 32'd2, "div_-7/2");
      run(2, 32'd100, 32'd0, "div_by_zero");
      run(2, 32'h8000_0000, 32'hFFFF_FFFF, "div_intmin_-1");
      run(2, 32'h8000_0000, 32'd2, "div_intmin_2");
      run(3, 32'd6, 32'd4, "both_high");
      start(1, 32'd5, 32'd5, "mul_aborted");
      repeat (9) @(posedge clock);
      run(2, 32'd9, 32'd3, "div_restart");
      start(1, 32'd12345, -32'sd678, "mul_b2b_a");
      repeat (32) @(posedge clock);
      run(2, -32'sd1000, 32'd7, "div_b2b_b");
      start(2, 32'd1000, 32'd3, "div_reset");
      repeat (15) @(posedge clock);
      #1;
      reset = 1'b1;
      sb.delete();
      #1;
      check("areset_result", data_result, 32'd0);
      check("areset_exception", 32'(data_exception), 32'd0);
      check("areset_rdy", 32'(data_resultRDY), 32'd0);
      check("areset_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (40) @(negedge clock);
      run(1, -32'sd11, -32'sd13, "mul_after_reset");
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(1, 2);
         x  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: y = 32'hFFFF_FFFF;
            2, 3: y = 32'($signed($urandom_range(0, 200)) - 100);
            default: y = $urandom;
         endcase
         if ($urandom_range(0, 1) == 1) x = 32'($signed($urandom_range(0, 200000)) - 100000);
         run(op, x, y, op == 1 ? "rand_mul" : "rand_div");
      end
      repeat (3) @(negedge clock);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
